// File: rtl/mips_trace_reader.sv
// mips_trace_reader
//   Captures a {PC, IR} entry into an internal FIFO each time the mips core
//   presents a new instruction on its debug bus. The FIFO is drained as a
//   valid/ready stream of two 32-bit words per entry: the byte PC (header),
//   then IR (body, flagged by rd_last). Captures that find the FIFO full are
//   dropped, flagged in the sticky overflow bit and counted in drop_cnt.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   en             capture enable; low disarms change detection
//   clr            synchronous flush of FIFO, overflow, drop_cnt and arming
//   PC[29:0]       word PC (PC[31:2]) from mips
//   IR[31:0]       instruction register from mips
//   rd_data        stream word (byte PC or IR)
//   rd_valid       rd_data valid
//   rd_ready       consumer accepts the current word
//   rd_last        current word is the IR word of an entry
//   level          entries stored, 0..DEPTH
//   overflow       sticky: at least one capture was dropped
//   drop_cnt       dropped captures, saturating at 16'hFFFF
module mips_trace_reader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [29:0]   PC,
  input  logic [31:0]   IR,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [61:0]   mem_r [DEPTH];
  logic [AW-1:0] wp_r;
  logic [AW-1:0] rp_r;
  logic [AW:0]   level_r;
  logic          armed_r;
  logic [29:0]   last_pc_r;
  logic [31:0]   last_ir_r;
  logic          overflow_r;
  logic [15:0]   drop_cnt_r;
  state_t        state_r;
  state_t        state_next_s;

  logic          cap_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [AW:0]   level_next_s;

  // Capture detection and FIFO push/pop/drop decisions.
  always_comb begin
    cap_s        = 1'b0;
    pop_s        = 1'b0;
    push_s       = 1'b0;
    drop_s       = 1'b0;
    level_next_s = level_r;
    // clr suppresses any capture in its cycle
    if (en && !clr) begin
      cap_s = !armed_r || (PC != last_pc_r) || (IR != last_ir_r);
    end else begin
      cap_s = 1'b0;
    end
    pop_s = (state_r == BODY) && rd_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    if (cap_s && ((level_r < DEPTH_L) || pop_s)) begin
      push_s = 1'b1;
    end else if (cap_s) begin
      drop_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    level_next_s = level_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
  end

  // Stream FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (level_r != '0) state_next_s = HDR;
        else               state_next_s = IDLE;
      end
      HDR: begin
        if (rd_ready) state_next_s = BODY;
        else          state_next_s = HDR;
      end
      BODY: begin
        // back-to-back entries go straight to HDR with no bubble
        if (rd_ready && (level_next_s != '0)) state_next_s = HDR;
        else if (rd_ready)                   state_next_s = IDLE;
        else                                 state_next_s = BODY;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Stream output decode from registered state and FIFO head.
  always_comb begin
    rd_data = 32'd0;
    rd_last = 1'b0;
    case (state_r)
      IDLE: begin
        rd_data = 32'd0;
        rd_last = 1'b0;
      end
      HDR: begin
        rd_data = {mem_r[rp_r][61:32], 2'b00};
        rd_last = 1'b0;
      end
      BODY: begin
        rd_data = mem_r[rp_r][31:0];
        rd_last = 1'b1;
      end
      default: begin
        rd_data = 32'd0;
        rd_last = 1'b0;
      end
    endcase
  end

  assign rd_valid = (state_r != IDLE);
  assign level    = level_r;
  assign overflow = overflow_r;
  assign drop_cnt = drop_cnt_r;

  // FIFO storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wp_r] <= {PC, IR};
  end

  // Pointers, level, arming, change-detect history, overflow accounting, FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_r       <= '0;
      rp_r       <= '0;
      level_r    <= '0;
      armed_r    <= 1'b0;
      last_pc_r  <= 30'd0;
      last_ir_r  <= 32'd0;
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
      state_r    <= IDLE;
    end else if (clr) begin
      wp_r       <= '0;
      rp_r       <= '0;
      level_r    <= '0;
      armed_r    <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'd0;
      state_r    <= IDLE;
    end else begin
      state_r <= state_next_s;
      level_r <= level_next_s;
      if (push_s) wp_r <= wp_r + AW'(1);
      if (pop_s)  rp_r <= rp_r + AW'(1);
      // history updates even on a drop so the same instruction is not retried
      if (!en) begin
        armed_r <= 1'b0;
      end else if (cap_s) begin
        armed_r   <= 1'b1;
        last_pc_r <= PC;
        last_ir_r <= IR;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_trace_reader.sv
module tb_mips_trace_reader;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic [29:0] pc;
  logic [31:0] ir;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic [AW:0] level;
  logic        overflow;
  logic [15:0] drop_cnt;

  mips_trace_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .PC       (pc),
    .IR       (ir),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_last  (rd_last),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: entry queue plus stream position, not the RTL FSM.
  logic [61:0] q [$];
  logic [31:0] seen [$];
  bit          m_armed;
  logic [29:0] m_last_pc;
  logic [31:0] m_last_ir;
  bit          m_ovf;
  int          m_drop;
  bit          m_half;   // 1 once the header word of q[0] has been consumed
  bit          m_valid;  // expected rd_valid

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    m_armed   = 1'b0;
    m_last_pc = 30'd0;
    m_last_ir = 32'd0;
    m_ovf     = 1'b0;
    m_drop    = 0;
    m_half    = 1'b0;
    m_valid   = 1'b0;
  endtask

  // Compare outputs against the model, advance the model by one clock,
  // and return at the following falling edge.
  task automatic tick();
    logic [61:0] e;
    bit          hs;
    bit          popped;
    bit          cap;
    bit          v_before;
    int          sz_before;
    check("rd_valid", {63'd0, rd_valid}, {63'd0, m_valid});
    if (m_valid && q.size() != 0) begin
      e = q[0];
      if (!m_half) begin
        check("hdr_data", {32'd0, rd_data}, {32'd0, e[61:32], 2'b00});
        check("hdr_last", {63'd0, rd_last}, 64'd0);
      end else begin
        check("body_data", {32'd0, rd_data}, {32'd0, e[31:0]});
        check("body_last", {63'd0, rd_last}, 64'd1);
      end
    end else begin
      check("idle_data", {32'd0, rd_data}, 64'd0);
      check("idle_last", {63'd0, rd_last}, 64'd0);
    end
    check("level", {59'd0, level}, 64'(q.size()));
    check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    check("drop_cnt", {48'd0, drop_cnt}, 64'(m_drop));

    hs        = m_valid && rd_ready;
    v_before  = m_valid;
    sz_before = q.size();
    popped    = 1'b0;
    if (hs) seen.push_back(rd_data);
    if (clr) begin
      q.delete();
      m_half  = 1'b0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_drop  = 0;
      m_armed = 1'b0;
    end else begin
      if (hs) begin
        if (!m_half) begin
          m_half = 1'b1;
        end else begin
          m_half = 1'b0;
          void'(q.pop_front());
          popped = 1'b1;
        end
      end
      cap = en && (!m_armed || pc != m_last_pc || ir != m_last_ir);
      if (cap) begin
        m_last_pc = pc;
        m_last_ir = ir;
        m_armed   = 1'b1;
        if (q.size() < DEPTH) begin
          q.push_back({pc, ir});
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
      if (!en) m_armed = 1'b0;
      // a word is offered one cycle after data lands from empty, otherwise continuously
      m_valid = m_half || (q.size() != 0 && (v_before || sz_before != 0));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [29:0] pc_pool [4];
  logic [31:0] ir_pool [4];
  logic [31:0] d0;
  logic        l0;
  int          guard;

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; pc = 30'd0; ir = 32'd0; rd_ready = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_level", {59'd0, level}, 64'd0);

    // Single held instruction gives exactly one entry
    en = 1'b1; pc = 30'h0000_0C00; ir = 32'h2008_0005; rd_ready = 1'b1;
    seen.delete();
    repeat (6) tick();
    check("t1_words", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) begin
      check("t1_hdr", {32'd0, seen[0]}, 64'h0000_3000);
      check("t1_ir", {32'd0, seen[1]}, 64'h2008_0005);
    end
    check("t1_level", {59'd0, level}, 64'd0);
    check("t1_idle", {63'd0, rd_valid}, 64'd0);

    // Three distinct instructions spaced 3 cycles apart
    seen.delete();
    for (int k = 0; k < 3; k++) begin
      pc = 30'h0000_0D00 + 30'(k); ir = $urandom;
      repeat (3) tick();
    end
    repeat (4) tick();
    check("t3_words", 64'(seen.size()), 64'd6);
    check("t3_ovf", {63'd0, overflow}, 64'd0);

    // Fill past capacity with consumer stalled
    rd_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      pc = 30'h0000_1000 + 30'(i); ir = $urandom;
      tick();
    end
    check("t4_level", {59'd0, level}, 64'd16);
    check("t4_ovf", {63'd0, overflow}, 64'd1);
    check("t4_drop", {48'd0, drop_cnt}, 64'd2);

    // Full FIFO: BODY handshake coincides with a new capture
    rd_ready = 1'b1;
    tick();
    pc = 30'h0000_2000; ir = $urandom;
    tick();
    check("t5_level", {59'd0, level}, 64'd16);
    check("t5_drop", {48'd0, drop_cnt}, 64'd2);

    // Stall in HDR for 5 cycles
    rd_ready = 1'b0;
    d0 = rd_data; l0 = rd_last;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_data", {32'd0, rd_data}, {32'd0, d0});
      check("stall_last", {63'd0, rd_last}, {63'd0, l0});
      check("stall_valid", {63'd0, rd_valid}, 64'd1);
    end

    // Drain to 4 entries, then flush
    rd_ready = 1'b1;
    guard = 0;
    while (q.size() > 4 && guard < 100) begin
      tick();
      guard++;
    end
    rd_ready = 1'b0;
    check("t7_level4", {59'd0, level}, 64'd4);
    check("t7_ovf", {63'd0, overflow}, 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t7_clr_level", {59'd0, level}, 64'd0);
    check("t7_clr_valid", {63'd0, rd_valid}, 64'd0);
    check("t7_clr_drop", {48'd0, drop_cnt}, 64'd0);
    tick();
    check("t7_recapture", {59'd0, level}, 64'd1);

    // Randomized traffic
    for (int i = 0; i < 4; i++) begin
      pc_pool[i] = 30'($urandom);
      ir_pool[i] = $urandom;
    end
    for (int i = 0; i < 2000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      rd_ready = ($urandom_range(0, 1) != 0);
      clr      = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 2) != 0) begin
        pc = pc_pool[$urandom_range(0, 3)];
        ir = ir_pool[$urandom_range(0, 3)];
      end
      tick();
    end
    clr = 1'b0; en = 1'b1;

    // Asynchronous reset in BODY
    rd_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pc = 30'h0000_3000; ir = 32'hDEAD_BEEF;
    guard = 0;
    while (!(m_valid && !m_half) && guard < 20) begin
      tick();
      guard++;
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("t9_in_body", {63'd0, rd_last}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t9_valid", {63'd0, rd_valid}, 64'd0);
    check("t9_last", {63'd0, rd_last}, 64'd0);
    check("t9_data", {32'd0, rd_data}, 64'd0);
    check("t9_level", {59'd0, level}, 64'd0);
    check("t9_ovf", {63'd0, overflow}, 64'd0);
    check("t9_drop", {48'd0, drop_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    rd_ready = 1'b1;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_trace_reader.md
# mips_trace_reader

Instruction-trace capture block that sits beside the `mips` top level and consumes its debug observation bus (`PC`, `IR`). Each time the core presents a new instruction, the block records a `{PC, IR}` entry in an internal FIFO. A host or testbench drains the FIFO over a valid/ready word stream: two 32-bit words per entry. Overflow is flagged and counted, never silently lost.

## Interface
- `DEPTH`, 16 — FIFO entries; power of two, ≥ 2.
- `AW`, 4 — log2(`DEPTH`).
- `clk`  in  1  — system clock, rising edge; same clock as `mips`.
- `rst`  in  1  — asynchronous, active-high reset.
- `en`  in  1  — capture enable; 0 disarms change detection.
- `clr`  in  1  — synchronous flush: empties FIFO, clears `overflow`/`drop_cnt`, disarms.
- `PC`  in  30  — `PC[31:2]` from `mips`.
- `IR`  in  32  — `IR` from `mips`.
- `rd_data`  out  32  — stream word.
- `rd_valid`  out  1  — `rd_data` valid.
- `rd_ready`  in  1  — consumer accepts the word.
- `rd_last`  out  1  — current word is the second (IR) word of an entry.
- `level`  out  AW+1  — entries stored, 0..`DEPTH`.
- `overflow`  out  1  — sticky: at least one capture dropped.
- `drop_cnt`  out  16  — dropped captures, saturates at 16'hFFFF.

## Operation
- Registers: `armed`, `last_pc[29:0]`, `last_ir[31:0]`, FIFO `mem[DEPTH]` of 62 bits, `wp`/`rp` (AW bits, wrap modulo `DEPTH`), `level`, FSM `state`.
- Capture condition `cap = en & (~armed | PC != last_pc | IR != last_ir)`.
- On `cap`: `last_pc <= PC`, `last_ir <= IR`, `armed <= 1`. This applies whether or not the entry is stored, so a dropped instruction is never re-captured.
- `en = 0`: `armed <= 0`. On re-enable, the current `{PC, IR}` is captured immediately, even if unchanged.
- Push:
  - If `cap` and (`level < DEPTH` or a pop occurs in the same cycle), write `mem[wp] <= {PC, IR}` and increment `wp`.
  - Otherwise, if `cap`, drop the entry: `overflow <= 1`, and `drop_cnt <= drop_cnt + 1` unless already 16'hFFFF.
- Pop: handshake (`rd_valid & rd_ready`) in state BODY increments `rp`.
- Level update: `level_next = level + push − pop`. Simultaneous push and pop leaves `level` unchanged, including when full.
- FSM (`rd_valid = (state != IDLE)`):
  - IDLE: `rd_last = 0`, `rd_data = 0`. Go to HDR when `level != 0`.
  - HDR: `rd_data = {mem[rp][61:32], 2'b00}` (byte PC), `rd_last = 0`. Handshake → BODY; otherwise hold.
  - BODY: `rd_data = mem[rp][31:0]` (IR), `rd_last = 1`. Handshake → pop, then HDR if `level_next != 0`, else IDLE; otherwise hold.
- Stream rules:
  - `rd_data` and `rd_last` are stable while `rd_valid & ~rd_ready`.
  - `rd_valid` never drops without a handshake, except on `clr` or `rst`.
- `clr` has priority over push and pop in the same cycle:
  - Clears `wp`, `rp`, `level`, `overflow`, `drop_cnt`, `armed`; `state <= IDLE`.
  - No capture that cycle.
- Reset mid-stream: an entry in flight is discarded; the consumer sees `rd_valid` fall asynchronously.

## Timing
- Reset values:
  - `rd_valid` 0, `rd_last` 0, `rd_data` 0, `level` 0, `overflow` 0, `drop_cnt` 0.
  - `state` IDLE, `armed` 0, `wp`/`rp` 0, `last_pc`/`last_ir` 0.
- A capture sampled at rising edge E updates `level` at E.
  - From empty: HDR is entered at E+1, so `rd_valid` rises after E+1. Latency is 1 cycle from the push edge to first word valid.
- Back-to-back entries with `rd_ready = 1`: 2 cycles per entry, no bubble between BODY and the next HDR.
- Sustained drain rate is 1 entry per 2 cycles. The `mips` core produces at most 1 instruction per ≥ 3 cycles, so no overflow occurs with `rd_ready` held at 1.
- All outputs are registered or decoded from registered state. There is no combinational path from `rd_ready` to `rd_valid`.

## Test plan
- Reset, `en = 1`, `PC = 30'h0000_0C00`, `IR = 32'h2008_0005` held → exactly one entry:
  - Words are 32'h0000_3000 (`rd_last = 0`), then 32'h2008_0005 (`rd_last = 1`).
  - `level` returns to 0 and FSM returns to IDLE.
- Three distinct `{PC, IR}` values spaced 3 cycles apart, `rd_ready = 1` → 6 words in order, `rd_last` pattern 0,1,0,1,0,1, `overflow = 0`.
- `rd_ready = 0` while 18 distinct instructions arrive with `DEPTH = 16`:
  - `level = 16`, `overflow = 1`, `drop_cnt = 2`.
  - Drain yields the first 16 entries in order.
- Full FIFO, BODY handshake coincident with a new capture → entry stored, `level` stays 16, `drop_cnt` unchanged.
- Stall: hold `rd_ready = 0` in HDR for 5 cycles → `rd_data` and `rd_last` constant, `rd_valid` stays 1.
- `clr` pulse with `level = 4`, `overflow = 1` → next cycle `level = 0`, `rd_valid = 0`, `drop_cnt = 0`; the unchanged `{PC, IR}` is recaptured on the following cycle.
- `rst` asserted asynchronously mid-BODY → all outputs reach reset values before the next clock edge.
